// File: rtl/float_add_arbiter_if.sv
// rtl/float_add_arbiter_if.sv - requester, datapath and response signals of the float add arbiter
interface float_add_arbiter_if #(
    parameter int WIDTH = 32
);
    logic [1:0]         reqValid;
    logic [1:0]         reqReady;
    logic [2*WIDTH-1:0] reqOpA;
    logic [2*WIDTH-1:0] reqOpB;
    logic [1:0]         reqSub;
    logic               dpValid;
    logic [WIDTH-1:0]   dpOpA;
    logic [WIDTH-1:0]   dpOpB;
    logic               dpSub;
    logic               dpDone;
    logic [WIDTH-1:0]   dpResult;
    logic [2:0]         dpFlags;
    logic               dpClear;
    logic [1:0]         respValid;
    logic [1:0]         respReady;
    logic [WIDTH-1:0]   respResult;
    logic [3:0]         respFlags;
    logic               busy;

    modport slave (
        input  reqValid, reqOpA, reqOpB, reqSub, dpDone, dpResult, dpFlags, respReady,
        output reqReady, dpValid, dpOpA, dpOpB, dpSub, dpClear, respValid, respResult,
        output respFlags, busy
    );

    modport master (
        output reqValid, reqOpA, reqOpB, reqSub, dpDone, dpResult, dpFlags, respReady,
        input  reqReady, dpValid, dpOpA, dpOpB, dpSub, dpClear, respValid, respResult,
        input  respFlags, busy
    );
endinterface

// File: rtl/float_add_arbiter.sv
// rtl/float_add_arbiter.sv - two-requester round-robin front end for a shared float add datapath
module float_add_arbiter #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                Clock,
    input  logic                Reset,
    float_add_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESPOND} state_t;

    localparam logic [7:0] TIMEOUT_M1 = 8'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic             grant_q;
    logic             last_grant_q;
    logic [WIDTH-1:0] opa_q, opb_q, result_q;
    logic             sub_q;
    logic [3:0]       flags_q;
    logic [7:0]       cnt_q;
    logic             clear_q;

    logic win;
    logic any_req;
    logic accept;
    logic dp_hit;
    logic timeout_hit;
    logic resp_fire;

    // On a tie the requester that was not served last time wins.
    assign any_req     = |bus.reqValid;
    assign win         = (bus.reqValid == 2'b11) ? ~last_grant_q : bus.reqValid[1];
    assign accept      = (state_q == IDLE) && any_req && !Reset;
    assign dp_hit      = (state_q == WAIT) && bus.dpDone;
    assign timeout_hit = (state_q == WAIT) && !bus.dpDone && (cnt_q == TIMEOUT_M1);
    assign resp_fire   = (state_q == RESPOND) && bus.respReady[grant_q];

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (dp_hit || timeout_hit) state_d = RESPOND;
            RESPOND: if (resp_fire) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.reqReady  = 2'b00;
        bus.dpValid   = 1'b0;
        bus.respValid = 2'b00;
        bus.busy      = (state_q != IDLE);
        case (state_q)
            IDLE:    if (accept) bus.reqReady = 2'b01 << win;
            ISSUE,
            WAIT:    bus.dpValid = 1'b1;
            RESPOND: bus.respValid = 2'b01 << grant_q;
            default: bus.busy = 1'b0;
        endcase
    end

    assign bus.dpOpA      = opa_q;
    assign bus.dpOpB      = opb_q;
    assign bus.dpSub      = sub_q;
    assign bus.dpClear    = clear_q;
    assign bus.respResult = result_q;
    assign bus.respFlags  = flags_q;

    // dpClear is a registered pulse raised on the WAIT->RESPOND edge only.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            opa_q        <= '0;
            opb_q        <= '0;
            sub_q        <= 1'b0;
            result_q     <= '0;
            flags_q      <= 4'b0000;
            cnt_q        <= 8'd0;
            clear_q      <= 1'b0;
        end else begin
            clear_q <= 1'b0;
            if (accept) begin
                grant_q <= win;
                opa_q   <= win ? bus.reqOpA[WIDTH +: WIDTH] : bus.reqOpA[0 +: WIDTH];
                opb_q   <= win ? bus.reqOpB[WIDTH +: WIDTH] : bus.reqOpB[0 +: WIDTH];
                sub_q   <= bus.reqSub[win];
            end
            if (state_q == ISSUE) begin
                cnt_q <= 8'd0;
            end
            if (dp_hit) begin
                result_q <= bus.dpResult;
                flags_q  <= {1'b0, bus.dpFlags};
                clear_q  <= 1'b1;
            end else if (timeout_hit) begin
                result_q <= '0;
                flags_q  <= 4'b1000;
                clear_q  <= 1'b1;
            end else if (state_q == WAIT) begin
                cnt_q <= cnt_q + 8'd1;
            end
            if (resp_fire) begin
                last_grant_q <= grant_q;
            end
        end
    end
endmodule

// File: tb/tb_float_add_arbiter.sv
// tb/tb_float_add_arbiter.sv - randomized transaction-level check of float_add_arbiter
module tb_float_add_arbiter;
    localparam int W  = 32;
    localparam int TO = 16;

    logic Clock = 1'b0;
    logic Reset;

    float_add_arbiter_if #(.WIDTH(W)) bus();

    float_add_arbiter #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clock = ~Clock;

    int vectors     = 0;
    int miscompares = 0;

    logic         chk_en = 1'b0;
    logic [1:0]   exp_ready, exp_rv;
    logic         exp_busy, exp_dpv, exp_clr, exp_sub;
    logic [W-1:0] exp_opa, exp_opb, exp_res;
    logic [3:0]   exp_flg;
    bit           lg;

    int           dpv_cnt, clr_cnt, rv_cnt;
    logic [1:0]   last_ready_obs, last_rv_obs;
    logic [W-1:0] last_res_obs;
    logic [3:0]   last_flg_obs;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge Clock) begin
        if (chk_en) begin
            check("reqReady", {62'd0, bus.reqReady}, {62'd0, exp_ready});
            check("ready_onehot", 64'($countones(bus.reqReady) <= 1), 64'd1);
            check("busy", {63'd0, bus.busy}, {63'd0, exp_busy});
            check("dpValid", {63'd0, bus.dpValid}, {63'd0, exp_dpv});
            check("dpClear", {63'd0, bus.dpClear}, {63'd0, exp_clr});
            check("respValid", {62'd0, bus.respValid}, {62'd0, exp_rv});
            if (exp_dpv) begin
                check("dpOpA", 64'(bus.dpOpA), 64'(exp_opa));
                check("dpOpB", 64'(bus.dpOpB), 64'(exp_opb));
                check("dpSub", {63'd0, bus.dpSub}, {63'd0, exp_sub});
            end
            if (exp_rv != 2'b00) begin
                check("respResult", 64'(bus.respResult), 64'(exp_res));
                check("respFlags", {60'd0, bus.respFlags}, {60'd0, exp_flg});
            end
            if (bus.dpValid) dpv_cnt++;
            if (bus.dpClear) clr_cnt++;
            if (bus.respValid != 2'b00) begin
                rv_cnt++;
                last_rv_obs  = bus.respValid;
                last_res_obs = bus.respResult;
                last_flg_obs = bus.respFlags;
            end
            if (bus.reqReady != 2'b00) last_ready_obs = bus.reqReady;
        end
    end

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic set_idle_exp();
        exp_ready = 2'b00;
        exp_busy  = 1'b0;
        exp_dpv   = 1'b0;
        exp_clr   = 1'b0;
        exp_rv    = 2'b00;
    endtask

    // One whole transaction: idle gap, grant, issue, wait (done on wait index k, or
    // timeout when k < 0), then a response held for 'hold' cycles before being consumed.
    task automatic run_op(input logic [1:0] v, input int idle_n, input int k, input int hold,
                          input logic [W-1:0] a0, input logic [W-1:0] b0,
                          input logic [W-1:0] a1, input logic [W-1:0] b1,
                          input logic [1:0] sub, input logic [W-1:0] dres,
                          input logic [2:0] dflg, output bit g);
        logic [W-1:0] er;
        logic [3:0]   ef;
        for (int i = 0; i < idle_n; i++) begin
            bus.reqValid  = 2'b00;
            bus.dpDone    = 1'($urandom);
            bus.dpResult  = W'($urandom);
            bus.respReady = 2'($urandom);
            set_idle_exp();
            step();
        end
        bus.reqValid  = v;
        bus.reqOpA    = {a1, a0};
        bus.reqOpB    = {b1, b0};
        bus.reqSub    = sub;
        bus.dpDone    = 1'($urandom);
        bus.respReady = 2'b00;
        g = (v == 2'b11) ? ~lg : v[1];
        set_idle_exp();
        exp_ready = 2'b01 << g;
        exp_opa   = g ? a1 : a0;
        exp_opb   = g ? b1 : b0;
        exp_sub   = sub[g];
        step();
        bus.reqValid = v | 2'($urandom);
        bus.reqOpA   = {$urandom, $urandom};
        bus.reqOpB   = {$urandom, $urandom};
        bus.reqSub   = 2'($urandom);
        bus.dpDone   = 1'($urandom);
        exp_ready    = 2'b00;
        exp_busy     = 1'b1;
        exp_dpv      = 1'b1;
        step();
        for (int i = 0; i < TO; i++) begin
            bus.dpDone   = (i == k);
            bus.dpResult = (i == k) ? dres : W'($urandom);
            bus.dpFlags  = (i == k) ? dflg : 3'($urandom);
            step();
            if (i == k) break;
        end
        er = (k >= 0) ? dres : '0;
        ef = (k >= 0) ? {1'b0, dflg} : 4'b1000;
        exp_dpv = 1'b0;
        exp_rv  = 2'b01 << g;
        exp_res = er;
        exp_flg = ef;
        for (int h = 0; h <= hold; h++) begin
            exp_clr        = (h == 0);
            bus.dpDone     = 1'($urandom);
            bus.dpResult   = W'($urandom);
            bus.reqValid   = 2'($urandom);
            bus.respReady  = 2'b00;
            bus.respReady[!g] = 1'($urandom);
            bus.respReady[g]  = (h == hold);
            step();
        end
        lg = g;
        bus.respReady = 2'b00;
        bus.reqValid  = 2'b00;
        bus.dpDone    = 1'b0;
        set_idle_exp();
    endtask

    // Start an op for requester 0, then reset it mid-WAIT with requester 1 pending.
    task automatic reset_in_wait();
        bus.reqValid = 2'b01;
        bus.reqOpA   = {$urandom, $urandom};
        bus.reqOpB   = {$urandom, $urandom};
        bus.reqSub   = 2'($urandom);
        bus.dpDone   = 1'b0;
        set_idle_exp();
        exp_ready = 2'b01;
        exp_opa   = bus.reqOpA[W-1:0];
        exp_opb   = bus.reqOpB[W-1:0];
        exp_sub   = bus.reqSub[0];
        step();
        bus.reqValid = 2'b10;
        exp_ready    = 2'b00;
        exp_busy     = 1'b1;
        exp_dpv      = 1'b1;
        for (int i = 0; i < 3; i++) step();
        Reset      = 1'b1;
        bus.dpDone = 1'b1;
        step();
        Reset      = 1'b0;
        bus.dpDone = 1'b0;
        lg         = 1'b1;
        set_idle_exp();
        check("rst_mid_dpOpA", 64'(bus.dpOpA), 64'd0);
        check("rst_mid_respFlags", {60'd0, bus.respFlags}, 64'd0);
        check("rst_mid_busy", {63'd0, bus.busy}, 64'd0);
    endtask

    logic [1:0] rr_exp [4];
    bit         g;
    int         kk;
    logic [1:0] vv;

    initial begin
        rr_exp        = '{2'b01, 2'b10, 2'b01, 2'b10};
        bus.reqValid  = 2'b00;
        bus.reqOpA    = '0;
        bus.reqOpB    = '0;
        bus.reqSub    = 2'b00;
        bus.dpDone    = 1'b0;
        bus.dpResult  = '0;
        bus.dpFlags   = 3'b000;
        bus.respReady = 2'b00;
        Reset         = 1'b1;
        lg            = 1'b1;
        dpv_cnt = 0; clr_cnt = 0; rv_cnt = 0;
        repeat (2) @(posedge Clock);
        #1;
        Reset = 1'b0;
        set_idle_exp();
        chk_en = 1'b1;
        check("rst_dpOpA", 64'(bus.dpOpA), 64'd0);
        check("rst_respResult", 64'(bus.respResult), 64'd0);
        check("rst_respFlags", {60'd0, bus.respFlags}, 64'd0);

        for (int i = 0; i < 4; i++) begin
            run_op(2'b11, 0, $urandom_range(0, 4), $urandom_range(0, 2),
                   $urandom, $urandom, $urandom, $urandom, 2'($urandom),
                   $urandom, 3'($urandom), g);
            check("rr_grant", {62'd0, last_ready_obs}, {62'd0, rr_exp[i]});
        end

        clr_cnt = 0;
        run_op(2'b01, 1, 2, 0, 32'h3F800000, 32'h40000000, $urandom, $urandom,
               2'b00, 32'h40400000, 3'b000, g);
        check("dir_respValid", {62'd0, last_rv_obs}, 64'h1);
        check("dir_respResult", 64'(last_res_obs), 64'h40400000);
        check("dir_respFlags", {60'd0, last_flg_obs}, 64'h0);
        check("dir_clear_pulses", 64'(clr_cnt), 64'd1);

        dpv_cnt = 0;
        run_op(2'b10, 0, -1, 1, $urandom, $urandom, $urandom, $urandom,
               2'($urandom), $urandom, 3'($urandom), g);
        check("to_dpValid_cycles", 64'(dpv_cnt), 64'd17);
        check("to_respFlags", {60'd0, last_flg_obs}, 64'h8);
        check("to_respResult", 64'(last_res_obs), 64'd0);

        run_op(2'b11, 0, TO - 1, 0, $urandom, $urandom, $urandom, $urandom,
               2'($urandom), 32'hDEADBEEF, 3'b010, g);
        check("late_done_flags", {60'd0, last_flg_obs}, 64'h2);

        rv_cnt = 0; clr_cnt = 0;
        run_op(2'b01, 0, 3, 5, $urandom, $urandom, $urandom, $urandom,
               2'($urandom), 32'h7F800000, 3'b100, g);
        check("hold_rv_cycles", 64'(rv_cnt), 64'd6);
        check("hold_clear_pulses", 64'(clr_cnt), 64'd1);
        check("hold_flags", {60'd0, last_flg_obs}, 64'h4);

        reset_in_wait();
        run_op(2'b10, 0, 1, 0, $urandom, $urandom, $urandom, $urandom,
               2'($urandom), $urandom, 3'($urandom), g);
        check("post_rst_grant", {62'd0, last_ready_obs}, 64'h2);

        for (int i = 0; i < 40; i++) begin
            vv = 2'($urandom_range(1, 3));
            kk = $urandom_range(0, 19);
            if (kk >= TO) kk = -1;
            run_op(vv, $urandom_range(0, 2), kk, $urandom_range(0, 3),
                   $urandom, $urandom, $urandom, $urandom, 2'($urandom),
                   $urandom, 3'($urandom), g);
        end

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/float_add_arbiter.md
FLOAT_ADD_ARBITER -- requirements
Module: float_add_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width (sign+exp+mantissa).
REQ-002 SHALL have parameter TIMEOUT, default 16, maximum WAIT cycles before abort (legal range 2..255).
REQ-003 SHALL have port Clock  in  1  sole clock, all state on rising edge.
REQ-004 SHALL have port Reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port reqValid  in  2  request valid, bit i = requester i.
REQ-006 SHALL have port reqReady  out  2  request accepted, bit i = requester i.
REQ-007 SHALL have port reqOpA  in  2*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH].
REQ-008 SHALL have port reqOpB  in  2*WIDTH  operand B, same packing.
REQ-009 SHALL have port reqSub  in  2  1 = A-B, 0 = A+B, per requester.
REQ-010 SHALL have port dpValid  out  1  operation valid to shared add/round datapath.
REQ-011 SHALL have ports dpOpA, dpOpB  out  WIDTH each  operands to datapath; dpSub  out  1  subtract control.
REQ-012 SHALL have port dpDone  in  1  datapath result valid.
REQ-013 SHALL have port dpResult  in  WIDTH  datapath result; dpFlags  in  3  {isInf,isNaN,isZero}.
REQ-014 SHALL have port dpClear  out  1  one-cycle clear to datapath (drives its ResultValid input).
REQ-015 SHALL have port respValid  out  2  response valid, bit i = requester i.
REQ-016 SHALL have port respReady  in  2  response consumed, bit i = requester i.
REQ-017 SHALL have port respResult  out  WIDTH  captured result; respFlags  out  4  {timeout,isInf,isNaN,isZero}.
REQ-018 SHALL have port busy  out  1  high whenever state != IDLE.

Function
REQ-019 SHALL implement FSM IDLE -> ISSUE -> WAIT -> RESPOND -> IDLE; one operation outstanding at a time.
REQ-020 IDLE: if any reqValid, grant g = the valid requester; if both valid, g = requester != lastGrant (round-robin).
REQ-021 reqReady[g] SHALL be combinational, high only in IDLE for the winner; operands/sub/g captured on that edge; next state ISSUE.
REQ-022 No reqValid in IDLE: remain IDLE, reqReady = 0, no capture.
REQ-023 ISSUE (1 cycle) and WAIT: dpValid = 1, dp operands = captured values, held stable until exit from WAIT.
REQ-024 ISSUE SHALL clear the 8-bit wait counter; WAIT increments it each cycle without dpDone.
REQ-025 dpDone SHALL be ignored outside WAIT.
REQ-026 WAIT with dpDone: capture dpResult, respFlags = {0,dpFlags}; next RESPOND.
REQ-027 WAIT, counter == TIMEOUT-1, no dpDone: respResult = 0, respFlags = 4'b1000; next RESPOND; dpDone in that same cycle wins over timeout.
REQ-028 dpClear SHALL be high exactly the first RESPOND cycle; dpValid = 0 throughout RESPOND and IDLE.
REQ-029 RESPOND: respValid[g] = 1, other bit 0, result/flags stable until respReady[g]; respReady[other] ignored.
REQ-030 On respValid[g] && respReady[g]: lastGrant <= g, next IDLE; new request grantable the following cycle.
REQ-031 Latency: accept at edge T; dpValid high cycles T+1..; dpDone at cycle T+k (k>=2) gives respValid from T+k+1.
REQ-032 Requester deasserting reqValid before grant SHALL leave no state change.

Reset
REQ-033 Reset SHALL force IDLE, lastGrant = 1 (requester 0 wins first tie), counter = 0.
REQ-034 Under Reset: reqReady, dpValid, dpClear, respValid, busy = 0; dpOpA/dpOpB/dpSub, respResult, respFlags = 0.
REQ-035 Reset mid-operation (any state) SHALL abort with no response and no dpClear; Reset overrides all inputs that cycle.

Verification
REQ-036 Single req0 1.0+2.0 (0x3F800000, 0x40000000, sub=0); dpDone after 2 WAIT cycles with 0x40400000 -> respValid=2'b01, respResult=0x40400000, respFlags=0, dpClear one pulse.
REQ-037 Both reqValid every cycle, 4 ops -> grants 0,1,0,1 after reset; reqReady never both high.
REQ-038 dpDone never asserted, TIMEOUT=16 -> respFlags=4'b1000, respResult=0 exactly 16 cycles after entering WAIT (counter 0..15).
REQ-039 dpDone with dpFlags=3'b100, respReady held low 5 cycles -> respValid/result stable 5 cycles, no new grant, then IDLE after respReady.
REQ-040 Reset asserted in WAIT -> next cycle busy=0, dpValid=0, respValid=0; pending req1 granted next IDLE cycle.
REQ-041 dpDone pulsed in IDLE/ISSUE -> ignored; response only from WAIT dpDone.
